// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the instruction fetch front end.
//   fetch_state_e        : fetch sequencer FSM states
//   XLEN_DEFAULT         : default address / instruction width
//   INSTR_BYTES          : bytes per instruction (sequential PC step)
//   RESET_VECTOR_DEFAULT : default PC after reset
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        FS_BOOT  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-memory request/grant/response bus and the
// fetch-to-decode valid/ready handshake.
//   imem_req/imem_addr      : fetch request and address (sequencer -> memory)
//   imem_gnt                : request accepted (memory -> sequencer)
//   imem_rvalid/imem_rdata  : read response (memory -> sequencer)
//   if_valid/if_pc/if_instr : instruction presented to decode
//   if_ready                : decode accepts the instruction
// Modports: master = fetch sequencer side, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface fetch_sequencer_if
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Combinational next-PC priority mux: trap > redirect > sequential > hold.
// A redirect whose target is not word-aligned is not taken; it is reported
// on misalign instead.
//   pc              : current program counter
//   advance         : current instruction accepted, step to pc + INSTR_BYTES
//   trap_en         : trap taken (already qualified by FSM state)
//   trap_vector     : trap handler address, used as given
//   redirect_en     : branch/jump taken (already qualified by FSM state)
//   redirect_target : branch/jump destination
//   next_pc         : value for the PC register next cycle
//   take_flush      : a trap or aligned redirect replaces the PC
//   misalign        : redirect requested to a non-word-aligned target
// ---------------------------------------------------------------------------
module next_pc_sel
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            take_flush,
    output logic            misalign
);
    logic target_aligned;

    assign target_aligned = (redirect_target[1:0] == 2'b00);

    always_comb begin
        next_pc    = pc;
        take_flush = 1'b0;
        misalign   = 1'b0;
        if (trap_en) begin
            next_pc    = trap_vector;
            take_flush = 1'b1;
        end else if (redirect_en) begin
            if (target_aligned) begin
                next_pc    = redirect_target;
                take_flush = 1'b1;
            end else begin
                misalign = 1'b1;
            end
        end else if (advance) begin
            // Wraps naturally modulo 2^XLEN.
            next_pc = pc + XLEN'(INSTR_BYTES);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter and runs one instruction fetch at a time:
// request the PC from instruction memory, wait for the response, present the
// word to decode, and advance (or redirect) once decode accepts it.
// Ports:
//   clk, rst_n            : core clock, asynchronous active-low reset
//   redirect_valid/target : branch/jump taken this cycle and its destination
//   trap_valid/vector     : trap taken this cycle and handler address
//   bus (master)          : imem request/grant/response + decode handshake
//   misalign_exc          : one-cycle pulse, redirect target not word-aligned
//   misalign_addr         : offending target, held until the next pulse
// ---------------------------------------------------------------------------
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_vector,
    fetch_sequencer_if.master bus,
    output logic              misalign_exc,
    output logic [XLEN-1:0]   misalign_addr
);
    localparam logic [2:0] S_BOOT  = FS_BOOT;
    localparam logic [2:0] S_REQ   = FS_REQ;
    localparam logic [2:0] S_WAIT  = FS_WAIT;
    localparam logic [2:0] S_HOLD  = FS_HOLD;
    localparam logic [2:0] S_FAULT = FS_FAULT;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_next;
    logic            kill_q, kill_d;
    logic            latch_en;
    logic [XLEN-1:0] if_pc_q, if_instr_q;

    logic trap_en, redirect_en, advance;
    logic take_flush, misalign;

    // Nothing redirects BOOT; FAULT only listens to traps.
    assign trap_en     = trap_valid && (state_q != S_BOOT);
    assign redirect_en = redirect_valid && (state_q != S_BOOT) && (state_q != S_FAULT);
    assign advance     = (state_q == S_HOLD) && bus.if_ready;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc              (pc_q),
        .advance         (advance),
        .trap_en         (trap_en),
        .trap_vector     (trap_vector),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .next_pc         (pc_next),
        .take_flush      (take_flush),
        .misalign        (misalign)
    );

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        latch_en = 1'b0;
        if (take_flush) begin
            case (state_q)
                S_REQ: begin
                    // Granted this cycle: a response for the old PC is coming.
                    if (bus.imem_gnt) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_FAULT: begin
                    // A response still owed from before the fault must be
                    // drained before the next request goes out.
                    if (kill_q && !bus.imem_rvalid) begin
                        state_d = S_WAIT;
                    end else begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else if (misalign) begin
            state_d = S_FAULT;
            if (state_q == S_REQ && bus.imem_gnt) begin
                kill_d = 1'b1;
            end else if (state_q == S_WAIT) begin
                kill_d = !bus.imem_rvalid;
            end
        end else begin
            case (state_q)
                S_BOOT: state_d = S_REQ;
                S_REQ: begin
                    if (bus.imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            latch_en = 1'b1;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.if_ready) begin
                        state_d = S_REQ;
                    end
                end
                S_FAULT: begin
                    // Stale response arriving while parked retires the kill.
                    if (kill_q && bus.imem_rvalid) begin
                        kill_d = 1'b0;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            kill_q        <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_next;
            kill_q       <= kill_d;
            misalign_exc <= misalign;
            if (misalign) begin
                misalign_addr <= redirect_target;
            end
            if (latch_en) begin
                if_pc_q    <= pc_q;
                if_instr_q <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (state_q == S_HOLD);
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;
endmodule
